// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the SAYEH memory bus arbiter.
// State encoding, owner codes, abort data and default bus widths.
package sayeh_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_CPU = 2'd1,
        ACC_DMA = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam logic [15:0] ABORT_DATA = 16'hFFFF;

    function automatic logic req_active(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the memory model.
// The arbiter uses the slave modport; the environment side uses master.
interface mem_bus_arbiter_if
    import sayeh_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              cpu_ReadMem;
    logic              cpu_WriteMem;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_memDataReady;

    logic              dma_rd;
    logic              dma_wr;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_done;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              owner;
    logic              busy;
    logic              err;

    modport slave (
        input  cpu_ReadMem, cpu_WriteMem, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_memDataReady,
        input  dma_rd, dma_wr, dma_addr, dma_wdata,
        output dma_rdata, dma_done,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output owner, busy, err
    );

    modport master (
        output cpu_ReadMem, cpu_WriteMem, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_memDataReady,
        output dma_rd, dma_wr, dma_addr, dma_wdata,
        input  dma_rdata, dma_done,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  owner, busy, err
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the CPU and DMA requesters.
// On a tie the requester that did not own the last grant wins.
module rr_arb2
    import sayeh_mem_pkg::*;
(
    input  logic req_cpu_i,
    input  logic req_dma_i,
    input  logic last_owner_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    always_comb begin
        grant_valid_o = req_cpu_i | req_dma_i;
        grant_id_o    = OWN_CPU;
        if (req_cpu_i && req_dma_i) begin
            grant_id_o = ~last_owner_i;
        end else if (req_dma_i) begin
            grant_id_o = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory between CPU and DMA ports, one registered transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to build the access watchdog (abort with all-ones data, sticky err).
module mem_bus_arbiter
    import sayeh_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input logic              clk,
    input logic              ExternalReset,
    mem_bus_arbiter_if.slave bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_bus_arbiter: TIMEOUT must be within 1..255");
    end

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              cpu_ready_q;
    logic              dma_done_q;

    logic              cpu_req;
    logic              dma_req;
    logic              grant_valid;
    logic              grant_id;

    logic              sel_rd;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              tmo_hit;
    logic              acc_end;
    logic              capture;
    logic [DATA_W-1:0] resp_data;

    assign cpu_req = req_active(bus.cpu_ReadMem, bus.cpu_WriteMem);
    assign dma_req = req_active(bus.dma_rd, bus.dma_wr);

    rr_arb2 u_rr_arb2 (
        .req_cpu_i     (cpu_req),
        .req_dma_i     (dma_req),
        .last_owner_i  (last_owner_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // Read wins when a requester raises both strobes at once.
    always_comb begin
        sel_rd    = bus.cpu_ReadMem;
        sel_wr    = bus.cpu_WriteMem & ~bus.cpu_ReadMem;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (grant_id == OWN_DMA) begin
            sel_rd    = bus.dma_rd;
            sel_wr    = bus.dma_wr & ~bus.dma_rd;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       err_q;
    logic       in_acc;

    assign in_acc    = (state_q == ACC_CPU) || (state_q == ACC_DMA);
    assign tmo_hit   = in_acc && !bus.mem_ready && (tmo_cnt_q == 8'(TIMEOUT - 1));
    assign resp_data = tmo_hit ? DATA_W'(ABORT_DATA) : bus.mem_rdata;

    // Counter sits at zero in IDLE, so every access starts from a clean count.
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                tmo_cnt_q <= '0;
            end else if (in_acc && !bus.mem_ready) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign resp_data = bus.mem_rdata;
    assign bus.err   = 1'b0;
`endif

    assign acc_end = bus.mem_ready | tmo_hit;
    assign capture = mem_read_q | tmo_hit;

    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DMA;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            dma_done_q   <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            dma_done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        mem_read_q   <= sel_rd;
                        mem_write_q  <= sel_wr;
                        mem_addr_q   <= sel_addr;
                        mem_wdata_q  <= sel_wdata;
                        owner_q      <= grant_id;
                        last_owner_q <= grant_id;
                        state_q      <= (grant_id == OWN_DMA) ? ACC_DMA : ACC_CPU;
                    end
                end
                ACC_CPU, ACC_DMA: begin
                    if (acc_end) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (state_q == ACC_CPU) begin
                            cpu_ready_q <= 1'b1;
                            if (capture) begin
                                cpu_rdata_q <= resp_data;
                            end
                        end else begin
                            dma_done_q <= 1'b1;
                            if (capture) begin
                                dma_rdata_q <= resp_data;
                            end
                        end
                        state_q <= RESP;
                    end
                end
                // Held level requests are ignored here so one access yields one pulse.
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read         = mem_read_q;
    assign bus.mem_write        = mem_write_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_wdata        = mem_wdata_q;
    assign bus.cpu_rdata        = cpu_rdata_q;
    assign bus.dma_rdata        = dma_rdata_q;
    assign bus.cpu_memDataReady = cpu_ready_q;
    assign bus.dma_done         = dma_done_q;
    assign bus.owner            = owner_q;
    assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (memory array, last-owner, per-port read shadows).
module tb_mem_bus_arbiter;
    import sayeh_mem_pkg::*;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic        model_last;
    logic [15:0] exp_cpu_rdata;
    logic [15:0] exp_dma_rdata;
    logic [15:0] mem_model [16];

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .ExternalReset (rst_n),
        .bus           (bus)
    );

    // {mem_read, mem_write, cpu_memDataReady, dma_done, busy, owner}
    function automatic logic [5:0] ctl();
        return {bus.mem_read, bus.mem_write, bus.cpu_memDataReady, bus.dma_done,
                bus.busy, bus.owner};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_ReadMem = 1'b0; bus.cpu_WriteMem = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_rd = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        model_last = OWN_DMA;
        exp_cpu_rdata = '0;
        exp_dma_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        tick();
        rst_n = 1'b0;
        #2;
        total++; if (ctl() !== 6'b000000) begin bad++;
            $display("FAIL reset_ctl: got %b want 000000", ctl()); end
        tick();
        total++; if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin bad++;
            $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
        total++; if ({bus.cpu_rdata, bus.dma_rdata} !== 32'h0) begin bad++;
            $display("FAIL reset_rdata: got %h want 0", {bus.cpu_rdata, bus.dma_rdata}); end
        total++; if (bus.err !== 1'b0) begin bad++;
            $display("FAIL reset_err: got %b want 0", bus.err); end
        do_reset();
        tick();
        total++; if (ctl() !== 6'b000000) begin bad++;
            $display("FAIL reset_release_idle: got %b want 000000", ctl()); end
    endtask

    task automatic test_cpu_read();
        bus.cpu_ReadMem = 1'b1;
        bus.cpu_addr    = 16'h0010;
        tick();
        total++; if (ctl() !== 6'b100010) begin bad++;
            $display("FAIL cpu_read_strobe: got %b want 100010", ctl()); end
        total++; if (bus.mem_addr !== 16'h0010) begin bad++;
            $display("FAIL cpu_read_addr: got %h want 0010", bus.mem_addr); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hA5A5; bus.cpu_ReadMem = 1'b0;
        tick();
        total++; if (ctl() !== 6'b001010) begin bad++;
            $display("FAIL cpu_read_pulse: got %b want 001010", ctl()); end
        total++; if (bus.cpu_rdata !== 16'hA5A5) begin bad++;
            $display("FAIL cpu_read_data: got %h want a5a5", bus.cpu_rdata); end
        bus.mem_ready = 1'b0;
        tick();
        total++; if (ctl() !== 6'b000000) begin bad++;
            $display("FAIL cpu_read_single_pulse: got %b want 000000", ctl()); end
        model_last = OWN_CPU;
        exp_cpu_rdata = 16'hA5A5;
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        bus.cpu_ReadMem = 1'b1; bus.cpu_addr = 16'h0001;
        bus.dma_wr = 1'b1; bus.dma_addr = 16'h0200; bus.dma_wdata = 16'h1234;
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h5A5A;
        tick();
        total++; if (ctl() !== 6'b100010 || bus.mem_addr !== 16'h0001) begin bad++;
            $display("FAIL tie_first_cpu: got %b/%h want 100010/0001", ctl(), bus.mem_addr); end
        tick();
        total++; if (ctl() !== 6'b001010 || bus.cpu_rdata !== 16'h5A5A) begin bad++;
            $display("FAIL tie_cpu_done: got %b/%h want 001010/5a5a", ctl(), bus.cpu_rdata); end
        bus.cpu_ReadMem = 1'b0;
        tick();
        total++; if (ctl() !== 6'b000000) begin bad++;
            $display("FAIL tie_idle_gap: got %b want 000000", ctl()); end
        tick();
        total++; if (ctl() !== 6'b010011) begin bad++;
            $display("FAIL tie_dma_write: got %b want 010011", ctl()); end
        total++; if (bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 16'h1234) begin bad++;
            $display("FAIL tie_dma_bus: got %h/%h want 0200/1234", bus.mem_addr, bus.mem_wdata); end
        bus.dma_wr = 1'b0;
        tick();
        total++; if (ctl() !== 6'b000111 || bus.dma_rdata !== 16'h0000) begin bad++;
            $display("FAIL tie_dma_done: got %b/%h want 000111/0000", ctl(), bus.dma_rdata); end
        bus.mem_ready = 1'b0;
        tick();
        total++; if (ctl() !== 6'b000001) begin bad++;
            $display("FAIL tie_end_idle: got %b want 000001", ctl()); end
        model_last = OWN_DMA;
        exp_cpu_rdata = 16'h5A5A;
    endtask

    task automatic test_rr_held();
        logic        own;
        logic [15:0] d;
        bus.cpu_ReadMem = 1'b1; bus.cpu_addr = 16'h0A0A;
        bus.dma_rd = 1'b1; bus.dma_addr = 16'h0B0B;
        bus.mem_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            own = ~model_last;
            d = 16'($urandom);
            bus.mem_rdata = d;
            tick();
            total++; if (ctl() !== {5'b10001, own}) begin bad++;
                $display("FAIL rr_grant_%0d: got %b want %b", r, ctl(), {5'b10001, own}); end
            total++; if (bus.mem_addr !== (own ? 16'h0B0B : 16'h0A0A)) begin bad++;
                $display("FAIL rr_addr_%0d: got %h", r, bus.mem_addr); end
            tick();
            total++; if (ctl() !== {2'b00, ~own, own, 1'b1, own}) begin bad++;
                $display("FAIL rr_pulse_%0d: got %b want %b", r, ctl(),
                         {2'b00, ~own, own, 1'b1, own}); end
            if (own) exp_dma_rdata = d; else exp_cpu_rdata = d;
            total++; if (bus.cpu_rdata !== exp_cpu_rdata || bus.dma_rdata !== exp_dma_rdata)
                begin bad++;
                $display("FAIL rr_data_%0d: got %h/%h want %h/%h", r, bus.cpu_rdata,
                         bus.dma_rdata, exp_cpu_rdata, exp_dma_rdata); end
            tick();
            total++; if (ctl() !== {5'b00000, own}) begin bad++;
                $display("FAIL rr_no_repeat_%0d: got %b want %b", r, ctl(), {5'b00000, own}); end
            model_last = own;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_wait_states();
        bus.dma_rd = 1'b1; bus.dma_addr = 16'h0033;
        tick();
        bus.dma_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (ctl() !== 6'b100011 || bus.mem_addr !== 16'h0033) begin bad++;
                $display("FAIL wait_hold_%0d: got %b/%h want 100011/0033", i, ctl(),
                         bus.mem_addr); end
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hC3C3;
        tick();
        total++; if (ctl() !== 6'b000111 || bus.dma_rdata !== 16'hC3C3) begin bad++;
            $display("FAIL wait_done: got %b/%h want 000111/c3c3", ctl(), bus.dma_rdata); end
        bus.mem_ready = 1'b0;
        tick();
        model_last = OWN_DMA;
        exp_dma_rdata = 16'hC3C3;
    endtask

    task automatic test_reset_mid();
        bus.cpu_WriteMem = 1'b1; bus.cpu_addr = 16'h0044; bus.cpu_wdata = 16'hBEEF;
        tick();
        total++; if (ctl() !== 6'b010010) begin bad++;
            $display("FAIL rmid_grant: got %b want 010010", ctl()); end
        bus.mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (ctl() !== 6'b000000 || {bus.mem_addr, bus.mem_wdata} !== 32'h0) begin bad++;
            $display("FAIL rmid_async: got %b/%h want 000000/0", ctl(),
                     {bus.mem_addr, bus.mem_wdata}); end
        tick();
        total++; if (ctl() !== 6'b000000 || bus.cpu_rdata !== 16'h0) begin bad++;
            $display("FAIL rmid_no_pulse: got %b/%h want 000000/0", ctl(), bus.cpu_rdata); end
        clear_inputs();
        rst_n = 1'b1;
        model_last = OWN_DMA;
        exp_cpu_rdata = '0;
        exp_dma_rdata = '0;
        bus.cpu_ReadMem = 1'b1; bus.dma_rd = 1'b1;
        tick();
        total++; if (ctl() !== 6'b100010) begin bad++;
            $display("FAIL rmid_tie_cpu: got %b want 100010", ctl()); end
        clear_inputs();
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h7E57;
        tick();
        total++; if (ctl() !== 6'b001010 || bus.cpu_rdata !== 16'h7E57) begin bad++;
            $display("FAIL rmid_tie_done: got %b/%h want 001010/7e57", ctl(), bus.cpu_rdata); end
        bus.mem_ready = 1'b0;
        tick();
        model_last = OWN_CPU;
        exp_cpu_rdata = 16'h7E57;
    endtask

    task automatic test_random();
        int unsigned ck, dk, waits;
        logic        c_act, d_act, own, rd;
        logic [15:0] ca, da, cw, dw, ea, ew;
        for (int it = 0; it < 40; it++) begin
            ck = $urandom_range(0, 3);
            dk = $urandom_range(0, 3);
            if (ck == 0 && dk == 0) ck = 1;
            ca = 16'($urandom); da = 16'($urandom); cw = 16'($urandom); dw = 16'($urandom);
            bus.cpu_ReadMem = ck[0]; bus.cpu_WriteMem = ck[1]; bus.cpu_addr = ca;
            bus.cpu_wdata = cw;
            bus.dma_rd = dk[0]; bus.dma_wr = dk[1]; bus.dma_addr = da; bus.dma_wdata = dw;
            bus.mem_ready = 1'($urandom_range(0, 1));
            c_act = (ck != 0);
            d_act = (dk != 0);
            own = (c_act && d_act) ? ~model_last : d_act;
            rd  = own ? dk[0] : ck[0];
            ea  = own ? da : ca;
            ew  = own ? dw : cw;
            tick();
            total++; if (ctl() !== {rd, ~rd, 3'b001, own} || bus.mem_addr !== ea ||
                         bus.mem_wdata !== ew) begin bad++;
                $display("FAIL rnd_grant_%0d: got %b/%h/%h want %b/%h/%h", it, ctl(),
                         bus.mem_addr, bus.mem_wdata, {rd, ~rd, 3'b001, own}, ea, ew); end
            bus.mem_ready = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                bus.cpu_ReadMem = 1'b0; bus.cpu_WriteMem = 1'b0;
                bus.dma_rd = 1'b0; bus.dma_wr = 1'b0;
            end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < int'(waits); w++) begin
                tick();
                total++; if (ctl() !== {rd, ~rd, 3'b001, own} || bus.mem_addr !== ea)
                    begin bad++;
                    $display("FAIL rnd_wait_%0d: got %b/%h", it, ctl(), bus.mem_addr); end
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd ? mem_model[ea[3:0]] : 16'($urandom);
            bus.cpu_ReadMem = 1'b0; bus.cpu_WriteMem = 1'b0;
            bus.dma_rd = 1'b0; bus.dma_wr = 1'b0;
            if (rd) begin
                if (own) exp_dma_rdata = mem_model[ea[3:0]];
                else     exp_cpu_rdata = mem_model[ea[3:0]];
            end else begin
                mem_model[ea[3:0]] = ew;
            end
            tick();
            total++; if (ctl() !== {2'b00, ~own, own, 1'b1, own} ||
                         bus.cpu_rdata !== exp_cpu_rdata || bus.dma_rdata !== exp_dma_rdata)
                begin bad++;
                $display("FAIL rnd_done_%0d: got %b/%h/%h want %b/%h/%h", it, ctl(),
                         bus.cpu_rdata, bus.dma_rdata, {2'b00, ~own, own, 1'b1, own},
                         exp_cpu_rdata, exp_dma_rdata); end
            bus.mem_ready = 1'($urandom_range(0, 1));
            tick();
            total++; if (ctl() !== {5'b00000, own}) begin bad++;
                $display("FAIL rnd_idle_%0d: got %b want %b", it, ctl(), {5'b00000, own}); end
            bus.mem_ready = 1'b0;
            model_last = own;
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.cpu_ReadMem = 1'b1; bus.cpu_addr = 16'h0055;
        tick();
        bus.cpu_ReadMem = 1'b0;
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            total++; if (ctl() !== 6'b100010 || bus.err !== 1'b0) begin bad++;
                $display("FAIL tmo_wait_%0d: got %b/%b want 100010/0", i, ctl(), bus.err); end
        end
        tick();
        total++; if (ctl() !== 6'b001010 || bus.cpu_rdata !== 16'hFFFF || bus.err !== 1'b1)
            begin bad++;
            $display("FAIL tmo_abort: got %b/%h/%b want 001010/ffff/1", ctl(), bus.cpu_rdata,
                     bus.err); end
        tick();
        tick();
        total++; if (ctl() !== 6'b000000 || bus.err !== 1'b1) begin bad++;
            $display("FAIL tmo_sticky: got %b/%b want 000000/1", ctl(), bus.err); end
        model_last = OWN_CPU;
        exp_cpu_rdata = 16'hFFFF;
    endtask
`endif

    initial begin
        clear_inputs();
        for (int i = 0; i < 16; i++) mem_model[i] = 16'($urandom);
        test_reset();
        test_cpu_read();
        test_tie_after_reset();
        test_rr_held();
        test_wait_states();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
